serial_xnor_compare: RTL
========================

SERIAL_XNOR_COMPARE -- requirements
Module: serial_xnor_compare

Interface
REQ-001 SHALL have parameter: WIDTH, 8, number of serial bit pairs per comparison word (2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request to begin a new comparison word.
REQ-005 SHALL have port: bit_valid  input  1  a_bit/b_bit carry a valid pair this cycle.
REQ-006 SHALL have port: a_bit  input  1  serial stream A, LSB first.
REQ-007 SHALL have port: b_bit  input  1  serial stream B, LSB first.
REQ-008 SHALL have port: busy  output  1  comparison in progress.
REQ-009 SHALL have port: done  output  1  one-cycle pulse, result valid.
REQ-010 SHALL have port: equal  output  1  all WIDTH pairs matched (XNOR=1 for every pair).
REQ-011 SHALL have port: mismatch_count  output  $clog2(WIDTH+1)  number of unequal pairs in last word.
REQ-012 SHALL have port: first_mismatch  output  $clog2(WIDTH)  bit index of first unequal pair; 0 when equal=1.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; all outputs registered.
REQ-014 IDLE: start=1 -> RUN next cycle; bit counter, mismatch_count, first_mismatch, mismatch flag cleared; busy=1 from the RUN cycle.
REQ-015 RUN: each cycle with bit_valid=1 SHALL sample a_bit/b_bit, compute XNOR, increment bit counter.
REQ-016 RUN: bit_valid=0 SHALL hold all state (stall, no timeout).
REQ-017 RUN: on XNOR=0, mismatch_count SHALL increment; if first mismatch of the word, first_mismatch SHALL load current bit index.
REQ-018 RUN: on the WIDTH-th valid pair -> DONE; equal and mismatch_count SHALL reflect all WIDTH pairs in the DONE cycle.
REQ-019 DONE: done=1 for exactly one cycle, busy=0; next state IDLE unless start=1, then RUN (back-to-back words, counters cleared).
REQ-020 start asserted in RUN SHALL be ignored.
REQ-021 bit_valid asserted in IDLE or DONE SHALL be ignored.
REQ-022 equal, mismatch_count, first_mismatch SHALL hold their values after DONE until the next start is accepted.
REQ-023 Latency: done SHALL assert the cycle after the WIDTH-th valid pair is sampled; minimum word time WIDTH+2 cycles from start.
REQ-024 mismatch_count SHALL saturate-free cover 0..WIDTH; bit counter SHALL not wrap within a word.

Reset
REQ-025 reset=1 SHALL force state IDLE, busy=0, done=0, equal=0, mismatch_count=0, first_mismatch=0, counter=0 at the next edge.
REQ-026 reset SHALL override all other inputs, including mid-RUN; the partial word SHALL be discarded with no done pulse.

Structure
REQ-027 Package serial_cmp_pkg SHALL hold the FSM state typedef (IDLE, RUN, DONE) and the WIDTH default constant.
REQ-028 One sub-module, xnor_cell (1-bit XNOR, combinational), SHALL compute per-pair equality; all sequential logic stays in serial_xnor_compare.

Verification (WIDTH=8)
REQ-029 Reset mid-RUN after 3 pairs -> busy=0, no done, all outputs 0; next start runs cleanly.
REQ-030 start, A=B=8'hA5 LSB first, bit_valid every cycle -> done 1 cycle at start+10, equal=1, mismatch_count=0, first_mismatch=0.
REQ-031 A=8'hF0, B=8'hF1 -> equal=0, mismatch_count=1, first_mismatch=0; A=8'h00, B=8'hFF -> mismatch_count=8, first_mismatch=0.
REQ-032 A=8'h10, B=8'h00 with bit_valid low on alternate cycles -> done at start+17, equal=0, mismatch_count=1, first_mismatch=4.
REQ-033 start held high through a word, then high in DONE cycle -> second word starts immediately, RUN-phase start ignored, results of word 1 held until word 2 accepted.
REQ-034 bit_valid pulses in IDLE before start -> ignored; subsequent word result unaffected.

Source files
------------

// File: rtl/serial_xnor_compare_pkg.sv
// Shared definitions for the serial XNOR comparator.
//   state_t       : FSM state encoding (IDLE, RUN, DONE)
//   WIDTH_DEFAULT : default number of serial bit pairs per comparison word
package serial_cmp_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_xnor_compare_if.sv
// Handshake and result bundle of the serial XNOR comparator.
//   master : drives start, bit_valid, a_bit, b_bit (LSB first); observes results
//   slave  : the comparator; drives busy, done, equal, mismatch_count,
//            first_mismatch
interface serial_xnor_compare_if #(
  parameter int WIDTH = serial_cmp_pkg::WIDTH_DEFAULT
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int IDX_W = $clog2(WIDTH);

  logic             start;
  logic             bit_valid;
  logic             a_bit;
  logic             b_bit;
  logic             busy;
  logic             done;
  logic             equal;
  logic [CNT_W-1:0] mismatch_count;
  logic [IDX_W-1:0] first_mismatch;

  modport master (
    output start, bit_valid, a_bit, b_bit,
    input  busy, done, equal, mismatch_count, first_mismatch
  );

  modport slave (
    input  start, bit_valid, a_bit, b_bit,
    output busy, done, equal, mismatch_count, first_mismatch
  );

endinterface

// File: rtl/serial_xnor_compare_xnor_cell.sv
// Per-pair equality: y = 1 when a and b carry the same bit value.
//   a, b : the two serial bits of one pair
//   y    : XNOR of a and b
module xnor_cell (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = ~(a ^ b);

endmodule

// File: rtl/serial_xnor_compare.sv
// Serial word comparator. After start is accepted, WIDTH valid bit pairs are
// consumed LSB first; the word result (equal, mismatch_count, first_mismatch)
// is presented with a one-cycle done pulse and held until the next start is
// accepted.
//   clk   : single clock, rising edge
//   reset : synchronous, active-high; discards any word in progress
//   bus   : serial_xnor_compare_if slave modport (handshake, bits, results)
//
// Incoming pairs are registered before they are counted, so a pair offered in
// cycle N is counted at the end of cycle N+1 and done follows one cycle later.
module serial_xnor_compare
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input logic                  clk,
  input logic                  reset,
  serial_xnor_compare_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;

  logic             valid_q;
  logic             a_q;
  logic             b_q;
  logic             pair_eq;

  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] mismatch_q;
  logic [IDX_W-1:0] first_q;
  logic             equal_q;
  logic             busy_q;
  logic             done_q;

  logic             take;
  logic             last_pair;
  logic             accept_start;

  xnor_cell u_xnor_cell (
    .a (a_q),
    .b (b_q),
    .y (pair_eq)
  );

  // Only pairs that were captured while in RUN count toward the word.
  assign take         = (state == RUN) && valid_q;
  assign last_pair    = take && (bit_cnt == LAST_IDX);
  assign accept_start = (state != RUN) && bus.start;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    // NOTE: next state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last_pair) state_nxt = DONE;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      bit_cnt    <= '0;
      mismatch_q <= '0;
      first_q    <= '0;
      equal_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      valid_q <= bus.bit_valid && (state == RUN);
      a_q     <= bus.a_bit;
      b_q     <= bus.b_bit;
      busy_q  <= (state_nxt == RUN);
      done_q  <= (state_nxt == DONE);

      if (accept_start) begin
        bit_cnt    <= '0;
        mismatch_q <= '0;
        first_q    <= '0;
        equal_q    <= 1'b0;
      end else if (take) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
        if (!pair_eq) begin
          mismatch_q <= mismatch_q + CNT_W'(1);
          // A zero running count means this is the first unequal pair.
          if (mismatch_q == '0) first_q <= bit_cnt[IDX_W-1:0];
        end
        if (last_pair) equal_q <= pair_eq && (mismatch_q == '0);
      end
    end
  end

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.equal          = equal_q;
  assign bus.mismatch_count = mismatch_q;
  assign bus.first_mismatch = first_q;

endmodule
